// File: rtl/regfile_pkg.sv
// Shared widths, the register-0 address and the arbiter state encoding for the
// register-file writeback path.
package regfile_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int REG_DATA_W = 32;
   localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

   // Four bits is enough for the largest MAX_WAIT of 15.
   localparam int WAIT_CNT_W = 4;

   typedef enum logic {
      PRIO_A = 1'b0,
      PRIO_B = 1'b1
   } arb_state_t;

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// One writeback requester port: valid/ready handshake carrying a destination
// register and its data. The requester drives the master side.
interface regfile_write_arbiter_if
   import regfile_pkg::*;
#(
   parameter int ADDR_W = REG_ADDR_W,
   parameter int DATA_W = REG_DATA_W
) ();

   logic              valid;
   logic              ready;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] data;

   modport master (
      output valid,
      output addr,
      output data,
      input  ready
   );

   modport slave (
      input  valid,
      input  addr,
      input  data,
      output ready
   );

endinterface

// File: rtl/wb_grant_fsm.sv
// Grant logic for the shared write port: fixed priority to A, with a wait
// counter that hands one cycle of priority to B after MAX_WAIT losses.
module wb_grant_fsm
   import regfile_pkg::*;
#(
   parameter int MAX_WAIT = 3
) (
   input  logic clk,
   input  logic rst_n,
   input  logic a_valid,
   input  logic b_valid,
   output logic a_ready,
   output logic b_ready,
   output logic forced_b
);

   localparam logic [WAIT_CNT_W-1:0] MAX_WAIT_CNT = WAIT_CNT_W'(MAX_WAIT);

   arb_state_t            state_reg;
   arb_state_t            state_next;
   logic [WAIT_CNT_W-1:0] wait_cnt_reg;
   logic [WAIT_CNT_W-1:0] wait_cnt_next;
   logic                  b_lost;
   logic                  b_released;

   // B loses a cycle only when it is waiting and A takes the port instead.
   assign b_lost     = b_valid && a_ready;
   assign b_released = b_ready || !b_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= PRIO_A;
         wait_cnt_reg <= '0;
      end else begin
         state_reg    <= state_next;
         wait_cnt_reg <= wait_cnt_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      wait_cnt_next = wait_cnt_reg;

      if (b_released) begin
         wait_cnt_next = '0;
      end else if (b_lost) begin
         wait_cnt_next = wait_cnt_reg + 1'b1;
      end

      case (state_reg)
         PRIO_A: begin
            if (b_lost && (wait_cnt_reg + 1'b1 == MAX_WAIT_CNT)) begin
               state_next = PRIO_B;
            end
         end
         PRIO_B: begin
            // A B transfer or a withdrawn B request both end the forced cycle.
            if (b_released) begin
               state_next = PRIO_A;
            end
         end
         default: state_next = PRIO_A;
      endcase
   end

   always_comb begin
      a_ready  = 1'b0;
      b_ready  = 1'b0;
      forced_b = 1'b0;

      case (state_reg)
         PRIO_A: begin
            a_ready = a_valid;
            b_ready = b_valid && !a_valid;
         end
         PRIO_B: begin
            b_ready  = b_valid;
            a_ready  = a_valid && !b_valid;
            forced_b = 1'b1;
         end
         default: begin
            a_ready = a_valid;
            b_ready = b_valid && !a_valid;
         end
      endcase
   end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register file's single write port between the ALU (A) and the
// load/multi-cycle unit (B), registering the granted write toward the regfile.
module regfile_write_arbiter
   import regfile_pkg::*;
#(
   parameter int MAX_WAIT = 3,
   parameter int ADDR_W   = REG_ADDR_W,
   parameter int DATA_W   = REG_DATA_W
) (
   input  logic                   clk,
   input  logic                   rst_n,
   regfile_write_arbiter_if.slave a_port,
   regfile_write_arbiter_if.slave b_port,
   output logic                   reg_write,
   output logic [ADDR_W-1:0]      write_addr,
   output logic [DATA_W-1:0]      write_data,
   output logic                   forced_b
);

   localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

   logic              a_xfer;
   logic              b_xfer;
   logic              reg_write_reg;
   logic              reg_write_next;
   logic [ADDR_W-1:0] write_addr_reg;
   logic [ADDR_W-1:0] write_addr_next;
   logic [DATA_W-1:0] write_data_reg;
   logic [DATA_W-1:0] write_data_next;

   wb_grant_fsm #(
      .MAX_WAIT (MAX_WAIT)
   ) u_grant_fsm (
      .clk      (clk),
      .rst_n    (rst_n),
      .a_valid  (a_port.valid),
      .b_valid  (b_port.valid),
      .a_ready  (a_port.ready),
      .b_ready  (b_port.ready),
      .forced_b (forced_b)
   );

   assign a_xfer = a_port.valid && a_port.ready;
   assign b_xfer = b_port.valid && b_port.ready;

   // At most one port is granted per cycle, so the select order is immaterial.
   always_comb begin
      write_addr_next = write_addr_reg;
      write_data_next = write_data_reg;
      reg_write_next  = 1'b0;

      if (a_xfer) begin
         write_addr_next = a_port.addr;
         write_data_next = a_port.data;
         reg_write_next  = (a_port.addr != ZERO_ADDR);
      end else if (b_xfer) begin
         write_addr_next = b_port.addr;
         write_data_next = b_port.data;
         reg_write_next  = (b_port.addr != ZERO_ADDR);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         reg_write_reg  <= 1'b0;
         write_addr_reg <= '0;
         write_data_reg <= '0;
      end else begin
         reg_write_reg  <= reg_write_next;
         write_addr_reg <= write_addr_next;
         write_data_reg <= write_data_next;
      end
   end

   assign reg_write  = reg_write_reg;
   assign write_addr = write_addr_reg;
   assign write_data = write_data_reg;

endmodule
